// File: rtl/subsoc_wb_arb2_if.sv
// subsoc_wb_arb2_if: WISHBONE bus bundle between one initiator (master) and one target (slave)
interface subsoc_wb_arb2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic cyc, stb, we, ack;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w, dat_r;
  modport master (output cyc, stb, adr, sel, we, dat_w, input dat_r, ack);
  modport slave (input cyc, stb, adr, sel, we, dat_w, output dat_r, ack);
endinterface

// File: rtl/subsoc_wb_arb2.sv
// subsoc_wb_arb2: round-robin two-initiator WISHBONE arbiter, grant held while cyc is high.
// Define SUBSOC_ARB_TIMEOUT_EN to add the no-ack watchdog with sticky timeout_o.
module subsoc_wb_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  subsoc_wb_arb2_if.slave  i0,
  subsoc_wb_arb2_if.slave  i1,
  subsoc_wb_arb2_if.master t,
  output logic [1:0]       gnt_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state;
  logic last, req0, req1, g0, g1, gstb, fire;
  assign req0 = i0.cyc & i0.stb;
  assign req1 = i1.cyc & i1.stb;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gstb = g0 ? i0.stb : g1 & i1.stb;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      last <= 1'b1;
      gnt_o <= 2'b00;
    end else case (state)
      IDLE:
        if (req0 && (!req1 || last)) begin
          state <= GNT0;
          last <= 1'b0;
          gnt_o <= 2'b01;
        end else if (req1) begin
          state <= GNT1;
          last <= 1'b1;
          gnt_o <= 2'b10;
        end
      GNT0:
        if (!i0.cyc) begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      GNT1:
        if (!i1.cyc) begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      default: begin
        state <= IDLE;
        gnt_o <= 2'b00;
      end
    endcase
  assign t.cyc = g0 ? i0.cyc : g1 & i1.cyc;
  assign t.stb = gstb & ~fire;
  assign t.adr = g0 ? i0.adr : g1 ? i1.adr : {AW{1'b0}};
  assign t.sel = g0 ? i0.sel : g1 ? i1.sel : {(DW/8){1'b0}};
  assign t.we = g0 ? i0.we : g1 & i1.we;
  assign t.dat_w = g0 ? i0.dat_w : g1 ? i1.dat_w : {DW{1'b0}};
  assign i0.ack = g0 & (t.ack | fire);
  assign i1.ack = g1 & (t.ack | fire);
  assign i0.dat_r = g0 & ~fire ? t.dat_r : {DW{1'b0}};
  assign i1.dat_r = g1 & ~fire ? t.dat_r : {DW{1'b0}};
`ifdef SUBSOC_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  // Idle clears the counter, so every grant starts counting from zero
  assign fire = gstb && cnt == TIMEOUT_W'(TIMEOUT_CYC);
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt <= (state == IDLE || t.ack || fire) ? '0 : cnt + {{(TIMEOUT_W-1){1'b0}}, gstb};
      timeout_o <= timeout_o | fire;
    end
`else
  assign fire = 1'b0;
  assign timeout_o = 1'b0 && TIMEOUT_CYC > (1 << TIMEOUT_W);
`endif
endmodule
